// File: rtl/sram_port_ctrl.sv
// Asynchronous SRAM port controller: one strobed read or write per request, fixed-length strobes.
// Optional write readback verification is compiled in with `define SRAM_VERIFY_EN.
module sram_port_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 7
) (
    input  logic                clk_50,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    input  logic                err_clr,
    output logic                ready,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rdata,
    output logic                verify_err,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_data,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic [DATA_W/8-1:0] sram_be_n
);

    localparam int NB    = DATA_W / 8;
    localparam int WC    = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
    localparam int CNT_W = $clog2(WC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WC - 1);

`ifdef SRAM_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_END, S_RD, S_RD_END, S_VRD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_END, S_RD, S_RD_END} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               drive;
    logic [DATA_W-1:0]  wdata_l;

    // The bus is only ever driven from a register, so drive and oe_n switch on the same edge.
    assign sram_data = drive ? wdata_l : {DATA_W{1'bz}};

`ifdef SRAM_VERIFY_EN
    logic [NB-1:0] be_l;
    logic          verify_err_r;

    assign verify_err = verify_err_r;

    function automatic logic lane_mismatch(input logic [DATA_W-1:0] rd,
                                           input logic [DATA_W-1:0] wr,
                                           input logic [NB-1:0]     lanes);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < NB; i++)
            mask[i*8 +: 8] = {8{lanes[i]}};
        return |((rd ^ wr) & mask);
    endfunction

    always_ff @(posedge clk_50) begin
        if (req && ready)
            be_l <= be;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign verify_err     = 1'b0;
`endif

    // Data latch carries no reset: it is only observed while drive is set.
    always_ff @(posedge clk_50) begin
        if (req && ready)
            wdata_l <= wdata;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            rd_valid  <= 1'b0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= '1;
            drive     <= 1'b0;
`ifdef SRAM_VERIFY_EN
            verify_err_r <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
`ifdef SRAM_VERIFY_EN
            if (err_clr)
                verify_err_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req && ready) begin
                        sram_addr <= addr_in;
                        cnt       <= '0;
                        ready     <= 1'b0;
                        sram_ce_n <= 1'b0;
                        if (we) begin
                            state     <= S_WR;
                            sram_we_n <= (be == '0);
                            sram_be_n <= ~be;
                            drive     <= 1'b1;
                        end else begin
                            state     <= S_RD;
                            sram_oe_n <= 1'b0;
                            sram_be_n <= '0;
                        end
                    end
                end
                S_WR: begin
                    if (cnt == LAST) begin
                        state     <= S_WR_END;
                        cnt       <= '0;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WR_END: begin
                    cnt   <= '0;
                    drive <= 1'b0;
`ifdef SRAM_VERIFY_EN
                    state     <= S_VRD;
                    sram_oe_n <= 1'b0;
                    sram_be_n <= '0;
`else
                    state     <= S_IDLE;
                    ready     <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_be_n <= '1;
`endif
                end
                S_RD: begin
                    if (cnt == LAST) begin
                        state     <= S_RD_END;
                        cnt       <= '0;
                        rdata     <= sram_data;
                        rd_valid  <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= '1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RD_END: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    ready     <= 1'b1;
                    sram_ce_n <= 1'b1;
                end
`ifdef SRAM_VERIFY_EN
                // Set is written after the clear above, so a same-cycle mismatch wins.
                S_VRD: begin
                    if (cnt == LAST) begin
                        if (lane_mismatch(sram_data, wdata_l, be_l))
                            verify_err_r <= 1'b1;
                        state     <= S_IDLE;
                        cnt       <= '0;
                        ready     <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= '1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    ready     <= 1'b1;
                    drive     <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_be_n <= '1;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter ADDR_W, 20, SRAM address width in bits.
REQ-002 Parameter DATA_W, 16, SRAM data width in bits; SHALL be a multiple of 8; byte-lane count NB = DATA_W/8.
REQ-003 Parameter WAIT_CYC, 7, strobe length in clk_50 cycles for each read or write access; a value of 0 SHALL be treated as 1.
REQ-004 clk_50  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  1  access request; qualified by ready.
REQ-007 we  in  1  1 = write, 0 = read; sampled with req.
REQ-008 addr_in  in  ADDR_W  access address.
REQ-009 wdata  in  DATA_W  write data.
REQ-010 be  in  NB  byte enables, bit i = byte lane i; used for writes only.
REQ-011 err_clr  in  1  clears verify_err; single-cycle pulse.
REQ-012 ready  out  1  high only in IDLE; request accepted on the clock edge where req && ready.
REQ-013 rd_valid  out  1  one-cycle pulse; rdata valid.
REQ-014 rdata  out  DATA_W  registered read data; holds its value until the next read completes.
REQ-015 verify_err  out  1  sticky readback-mismatch flag.
REQ-016 sram_addr  out  ADDR_W  registered address.
REQ-017 sram_data  inout  DATA_W  bidirectional data bus.
REQ-018 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low chip, output and write enables.
REQ-019 sram_be_n  out  NB  active-low byte-lane enables.

Function
REQ-020 States: IDLE, WR, WR_END, RD, RD_END, VRD; the access counter SHALL be $clog2(WAIT_CYC+1) bits wide and cleared on every state entry.
REQ-021 IDLE: on acceptance, latch addr_in, wdata and be, then enter WR (we=1) or RD (we=0); otherwise remain in IDLE.
REQ-022 WR: lasts WAIT_CYC cycles; sram_we_n=0 unless be==0 (request still accepted, no strobe, same latency); sram_be_n=~be_latched; bus driven with wdata_latched; then WR_END.
REQ-023 WR_END: 1 cycle; sram_we_n=1; bus still driven (data hold); then IDLE, or VRD per REQ-035.
REQ-024 RD: lasts WAIT_CYC cycles; sram_oe_n=0; sram_be_n all 0; bus tristated; sram_data captured into rdata on the edge ending the last RD cycle; then RD_END.
REQ-025 RD_END: 1 cycle; rd_valid=1; then IDLE.
REQ-026 sram_ce_n=0 in every state except IDLE; in IDLE sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n all 1, bus tristated.
REQ-027 The bus SHALL be driven only in WR and WR_END; sram_oe_n and bus drive SHALL never be active in the same cycle.
REQ-028 Latency: ready deasserts for WAIT_CYC+1 cycles per access (without the verify feature); rd_valid is high in the cycle WAIT_CYC+1 cycles after the acceptance edge.
REQ-029 req held high in IDLE SHALL yield back-to-back accesses with exactly one IDLE cycle between them; req while ready=0 is ignored.
REQ-030 err_clr asserted in the same cycle as a new mismatch: set SHALL win.

Reset
REQ-031 While rst_n=0, asynchronously and regardless of the current state: state=IDLE; ready=1; rd_valid=0; rdata=0; verify_err=0; sram_addr=0; all SRAM strobes inactive (high); bus tristated.
REQ-032 A reset asserted mid-access SHALL abort the access and apply REQ-031 immediately; the aborted access SHALL NOT be retried.

Configuration
REQ-033 Macro SRAM_VERIFY_EN compiles in write readback verification.
REQ-034 Without the macro: VRD does not exist; verify_err is tied to 0; err_clr is ignored.
REQ-035 With the macro: WR_END always goes to VRD, including when be==0; VRD performs a read identical to RD for WAIT_CYC cycles with rd_valid held 0; at the end of VRD, compare the enabled lanes with wdata_latched; any mismatch sets verify_err; then IDLE; ready is low for 2*WAIT_CYC+1 cycles per write.

Verification
REQ-036 WAIT_CYC=7; write 0xA5A5 to 0x00010 with be=2'b11 -> sram_we_n low for 7 cycles, bus driven for 8 cycles, ready high again 8 cycles after acceptance.
REQ-037 Read 0x00010 from the SRAM model -> sram_oe_n low for 7 cycles, rd_valid pulse 8 cycles after acceptance, rdata=0xA5A5.
REQ-038 Write 0x1234 to 0x00010 with be=2'b01, then read -> rdata=0xA534.
REQ-039 req held high with alternating we -> one IDLE cycle between accesses, sram_data Z throughout every RD, no bus contention.
REQ-040 rst_n pulsed low in cycle 3 of WR -> sram_we_n=1, sram_ce_n=1 and bus Z with no clock edge; ready=1 after release; the model's memory location holds its old value.
REQ-041 SRAM_VERIFY_EN with model bit 0 stuck at 0; write 0x0001 -> verify_err=1 and stays 1 across later accesses; err_clr pulse -> verify_err=0.
